// File: rtl/udt_state_pkg.sv
// rtl/udt_state_pkg.sv - shared socket state codes, source indices, FSM encoding and helpers
// Purpose: common definitions for the UDT state request arbiter and its users.
// Ports: none (package).
package udt_state_pkg;

    localparam logic [7:0] ST_INIT       = 8'h00;
    localparam logic [7:0] ST_LISTENING  = 8'h01;
    localparam logic [7:0] ST_CONNECTING = 8'h02;
    localparam logic [7:0] ST_CONNECTED  = 8'h04;
    localparam logic [7:0] ST_CLOSING    = 8'h08;
    localparam logic [7:0] ST_SHUTDOWN   = 8'h10;
    localparam logic [7:0] ST_BROCKEN    = 8'h20;

    localparam logic [2:0] SRC_LISTEN   = 3'd0;
    localparam logic [2:0] SRC_CONNECT  = 3'd1;
    localparam logic [2:0] SRC_CLOSE    = 3'd2;
    localparam logic [2:0] SRC_SHUTDOWN = 3'd3;
    localparam logic [2:0] SRC_BROCKEN  = 3'd4;

    typedef enum logic {
        FSM_IDLE  = 1'b0,
        FSM_ISSUE = 1'b1
    } arb_fsm_e;

    // Requested target state for each source.
    function automatic logic [7:0] udt_state_code(input logic [2:0] src);
        case (src)
            SRC_LISTEN:   return ST_LISTENING;
            SRC_CONNECT:  return ST_CONNECTING;
            SRC_CLOSE:    return ST_CLOSING;
            SRC_SHUTDOWN: return ST_SHUTDOWN;
            SRC_BROCKEN:  return ST_BROCKEN;
            default:      return ST_INIT;
        endcase
    endfunction

    // Whether a request from src is allowed while the socket is in state cur.
    function automatic logic udt_state_legal(input logic [2:0] src, input logic [7:0] cur);
        case (src)
            SRC_LISTEN,
            SRC_CONNECT:  return (cur == ST_INIT);
            SRC_CLOSE:    return (cur == ST_LISTENING) || (cur == ST_CONNECTING) ||
                                 (cur == ST_CONNECTED);
            SRC_SHUTDOWN: return (cur == ST_CLOSING);
            SRC_BROCKEN:  return (cur == ST_CONNECTING) || (cur == ST_CONNECTED) ||
                                 (cur == ST_CLOSING);
            default:      return 1'b0;
        endcase
    endfunction

    // 16-bit saturating increment.
    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/udt_rr_arb4.sv
// rtl/udt_rr_arb4.sv - 4-way round-robin grant with pointer update
// Purpose: picks one of four requesters, searching upward from the stored pointer.
// Ports:
//   clk, rst    clock, synchronous active-high reset (pointer -> 0)
//   req_i[3:0]  request vector
//   adv_i       commit this cycle's grant: pointer moves to winner+1
//   gnt_o[3:0]  one-hot grant (combinational)
//   gnt_idx_o   index of the granted requester
//   gnt_any_o   some requester is granted
module udt_rr_arb4 (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req_i,
    input  logic       adv_i,
    output logic [3:0] gnt_o,
    output logic [1:0] gnt_idx_o,
    output logic       gnt_any_o
);

    logic [1:0] ptr_q, ptr_d;
    logic [1:0] cand;
    logic       found;
    logic [1:0] found_idx;

    always_comb begin
        found     = 1'b0;
        found_idx = ptr_q;
        cand      = ptr_q;
        for (int i = 0; i < 4; i++) begin
            cand = ptr_q + 2'(i);
            if (!found && req_i[cand]) begin
                found     = 1'b1;
                found_idx = cand;
            end
        end
        gnt_any_o = found;
        gnt_idx_o = found_idx;
        gnt_o     = found ? (4'b0001 << found_idx) : 4'b0000;
        ptr_d     = ptr_q;
        if (adv_i && found) begin
            ptr_d = found_idx + 2'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= 2'd0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/udt_state_req_arbiter.sv
// rtl/udt_state_req_arbiter.sv - arbitrates socket state-change requests toward the state manager
// Purpose: grants one request at a time (BROCKEN first, others round-robin), checks it against
//   the tracked socket state, and issues legal ones over a valid/ready channel with a timeout.
// Optional feature: macro STATE_ARB_STATS_EN adds saturating grant/reject/timeout counters.
// Ports:
//   core_clk, core_rst    clock, synchronous active-high reset
//   req_valid_i[4:0]      [0]LISTEN [1]CONNECT [2]CLOSE [3]SHUTDOWN [4]BROCKEN
//   req_ready_o[4:0]      one-hot accept, combinational in IDLE
//   evt_state_o[7:0]      one-hot requested state code
//   evt_valid_o           event valid
//   evt_ready_i           state manager accepts event
//   udt_state_i[31:0]     state from state manager ([7:0] used)
//   udt_state_valid_i     udt_state_i valid
//   udt_state_ready_o     always 1
//   cur_state_o[7:0]      tracked socket state
//   reject_o, timeout_o   1-cycle pulses
//   busy_o                FSM not idle
//   stat_clr_i, stat_grant_cnt_o[79:0], stat_reject_cnt_o[15:0], stat_timeout_cnt_o[15:0]
//                         (STATE_ARB_STATS_EN only)
module udt_state_req_arbiter
    import udt_state_pkg::*;
#(
    parameter int TIMEOUT_CYC = 1000,
    parameter int TMR_W       = 16
) (
    input  logic        core_clk,
    input  logic        core_rst,
    input  logic [4:0]  req_valid_i,
    output logic [4:0]  req_ready_o,
    output logic [7:0]  evt_state_o,
    output logic        evt_valid_o,
    input  logic        evt_ready_i,
    input  logic [31:0] udt_state_i,
    input  logic        udt_state_valid_i,
    output logic        udt_state_ready_o,
    output logic [7:0]  cur_state_o,
    output logic        reject_o,
    output logic        timeout_o,
    output logic        busy_o
`ifdef STATE_ARB_STATS_EN
    ,
    input  logic        stat_clr_i,
    output logic [79:0] stat_grant_cnt_o,
    output logic [15:0] stat_reject_cnt_o,
    output logic [15:0] stat_timeout_cnt_o
`endif
);

    arb_fsm_e         state_q, state_d;
    logic [2:0]       idx_q, idx_d;
    logic [TMR_W-1:0] timer_q, timer_d;
    logic [7:0]       cur_state_q, cur_state_d;
    logic             reject_q, reject_d;
    logic             timeout_q, timeout_d;

    logic [3:0]       rr_gnt;
    logic [1:0]       rr_idx;
    logic             rr_any;
    logic             rr_adv;
    logic             grant;
    logic [2:0]       grant_idx;
    logic [23:0]      udt_state_hi_unused;

    assign udt_state_hi_unused = udt_state_i[31:8];

    // BROCKEN pre-empts the round-robin, so only commit the pointer when it is absent.
    assign rr_adv = (state_q == FSM_IDLE) && !req_valid_i[SRC_BROCKEN];

    udt_rr_arb4 u_rr (
        .clk       (core_clk),
        .rst       (core_rst),
        .req_i     (req_valid_i[3:0]),
        .adv_i     (rr_adv),
        .gnt_o     (rr_gnt),
        .gnt_idx_o (rr_idx),
        .gnt_any_o (rr_any)
    );

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        timer_d     = timer_q;
        reject_d    = 1'b0;
        timeout_d   = 1'b0;
        req_ready_o = 5'b00000;
        grant       = 1'b0;
        grant_idx   = idx_q;
        // The state manager is authoritative; legality below still uses the registered value.
        cur_state_d = udt_state_valid_i ? udt_state_i[7:0] : cur_state_q;

        case (state_q)
            FSM_IDLE: begin
                timer_d = '0;
                if (req_valid_i[SRC_BROCKEN]) begin
                    grant       = 1'b1;
                    grant_idx   = SRC_BROCKEN;
                    req_ready_o = 5'b10000;
                end else if (rr_any) begin
                    grant       = 1'b1;
                    grant_idx   = {1'b0, rr_idx};
                    req_ready_o = {1'b0, rr_gnt};
                end
                if (grant) begin
                    idx_d = grant_idx;
                    if (udt_state_legal(grant_idx, cur_state_q)) begin
                        state_d = FSM_ISSUE;
                    end else begin
                        reject_d = 1'b1;
                    end
                end
            end
            FSM_ISSUE: begin
                // A handshake on the last allowed cycle takes precedence over the timeout.
                if (evt_ready_i) begin
                    state_d = FSM_IDLE;
                    timer_d = '0;
                end else if (timer_q == TMR_W'(TIMEOUT_CYC - 1)) begin
                    state_d   = FSM_IDLE;
                    timer_d   = '0;
                    timeout_d = 1'b1;
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                end
            end
            default: state_d = FSM_IDLE;
        endcase
    end

    always_ff @(posedge core_clk) begin
        if (core_rst) begin
            state_q     <= FSM_IDLE;
            idx_q       <= 3'd0;
            timer_q     <= '0;
            cur_state_q <= ST_INIT;
            reject_q    <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            timer_q     <= timer_d;
            cur_state_q <= cur_state_d;
            reject_q    <= reject_d;
            timeout_q   <= timeout_d;
        end
    end

    assign evt_valid_o       = (state_q == FSM_ISSUE);
    assign evt_state_o       = evt_valid_o ? udt_state_code(idx_q) : 8'h00;
    assign busy_o            = (state_q != FSM_IDLE);
    assign cur_state_o       = cur_state_q;
    assign reject_o          = reject_q;
    assign timeout_o         = timeout_q;
    assign udt_state_ready_o = 1'b1;

`ifdef STATE_ARB_STATS_EN
    logic [4:0][15:0] grant_cnt_q, grant_cnt_d;
    logic [15:0]      reject_cnt_q, reject_cnt_d;
    logic [15:0]      timeout_cnt_q, timeout_cnt_d;

    always_comb begin
        grant_cnt_d   = grant_cnt_q;
        reject_cnt_d  = reject_cnt_q;
        timeout_cnt_d = timeout_cnt_q;
        if (stat_clr_i) begin
            grant_cnt_d   = '0;
            reject_cnt_d  = '0;
            timeout_cnt_d = '0;
        end else begin
            if (grant) begin
                grant_cnt_d[grant_idx] = sat_inc16(grant_cnt_q[grant_idx]);
            end
            if (reject_d) begin
                reject_cnt_d = sat_inc16(reject_cnt_q);
            end
            if (timeout_d) begin
                timeout_cnt_d = sat_inc16(timeout_cnt_q);
            end
        end
    end

    always_ff @(posedge core_clk) begin
        if (core_rst) begin
            grant_cnt_q   <= '0;
            reject_cnt_q  <= '0;
            timeout_cnt_q <= '0;
        end else begin
            grant_cnt_q   <= grant_cnt_d;
            reject_cnt_q  <= reject_cnt_d;
            timeout_cnt_q <= timeout_cnt_d;
        end
    end

    assign stat_grant_cnt_o   = grant_cnt_q;
    assign stat_reject_cnt_o  = reject_cnt_q;
    assign stat_timeout_cnt_o = timeout_cnt_q;
`endif

endmodule

// File: tb/tb_udt_state_req_arbiter.sv
// tb/tb_udt_state_req_arbiter.sv - scoreboard bench for udt_state_req_arbiter
module tb_udt_state_req_arbiter;

    localparam int K_HS  = 0;
    localparam int K_REJ = 1;
    localparam int K_TMO = 2;

    logic        core_clk = 1'b0;
    logic        core_rst = 1'b1;
    logic [4:0]  req_valid_i = '0;
    logic [4:0]  req_ready_o;
    logic [7:0]  evt_state_o;
    logic        evt_valid_o;
    logic        evt_ready_i = 1'b0;
    logic [31:0] udt_state_i = '0;
    logic        udt_state_valid_i = 1'b0;
    logic        udt_state_ready_o;
    logic [7:0]  cur_state_o;
    logic        reject_o;
    logic        timeout_o;
    logic        busy_o;
`ifdef STATE_ARB_STATS_EN
    logic        stat_clr_i = 1'b0;
    logic [79:0] stat_grant_cnt_o;
    logic [15:0] stat_reject_cnt_o;
    logic [15:0] stat_timeout_cnt_o;
`endif

    typedef struct {
        int         kind;
        logic [7:0] code;
    } exp_t;

    exp_t sb_q[$];
    int   tests_run    = 0;
    int   tests_failed = 0;

    always #5 core_clk = ~core_clk;

    udt_state_req_arbiter #(.TIMEOUT_CYC(8), .TMR_W(16)) dut (
        .core_clk          (core_clk),
        .core_rst          (core_rst),
        .req_valid_i       (req_valid_i),
        .req_ready_o       (req_ready_o),
        .evt_state_o       (evt_state_o),
        .evt_valid_o       (evt_valid_o),
        .evt_ready_i       (evt_ready_i),
        .udt_state_i       (udt_state_i),
        .udt_state_valid_i (udt_state_valid_i),
        .udt_state_ready_o (udt_state_ready_o),
        .cur_state_o       (cur_state_o),
        .reject_o          (reject_o),
        .timeout_o         (timeout_o),
        .busy_o            (busy_o)
`ifdef STATE_ARB_STATS_EN
        ,
        .stat_clr_i         (stat_clr_i),
        .stat_grant_cnt_o   (stat_grant_cnt_o),
        .stat_reject_cnt_o  (stat_reject_cnt_o),
        .stat_timeout_cnt_o (stat_timeout_cnt_o)
`endif
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic sb_push(input int kind, input logic [7:0] code);
        exp_t e;
        e.kind = kind;
        e.code = code;
        sb_q.push_back(e);
    endtask

    task automatic sb_pop_check(input string tag, input int kind, input logic [7:0] code);
        exp_t e;
        if (sb_q.size() == 0) begin
            check_val({tag, "_unexpected"}, 32'd1, 32'd0);
            return;
        end
        e = sb_q.pop_front();
        check_val({tag, "_kind"}, kind, e.kind);
        if (kind == K_HS) begin
            check_val({tag, "_code"}, code, e.code);
        end
    endtask

    always @(negedge core_clk) begin
        if (!core_rst) begin
            if (evt_valid_o && evt_ready_i) sb_pop_check("sb_hs", K_HS, evt_state_o);
            if (reject_o)                   sb_pop_check("sb_rej", K_REJ, 8'h00);
            if (timeout_o)                  sb_pop_check("sb_tmo", K_TMO, 8'h00);
        end
    end

    task automatic tick();
        @(posedge core_clk);
        #1;
    endtask

    task automatic set_state(input logic [7:0] v);
        udt_state_i       = {24'hABCDEF, v};
        udt_state_valid_i = 1'b1;
        tick();
        udt_state_valid_i = 1'b0;
        check_val("cur_state_upd", cur_state_o, v);
    endtask

    task automatic do_reset();
        core_rst    = 1'b1;
        req_valid_i = '0;
        evt_ready_i = 1'b0;
        tick();
        tick();
        check_val("rst_req_ready", req_ready_o, 0);
        check_val("rst_evt_valid", evt_valid_o, 0);
        check_val("rst_evt_state", evt_state_o, 0);
        check_val("rst_cur_state", cur_state_o, 0);
        check_val("rst_reject", reject_o, 0);
        check_val("rst_timeout", timeout_o, 0);
        check_val("rst_busy", busy_o, 0);
        check_val("rst_udt_ready", udt_state_ready_o, 1);
        core_rst = 1'b0;
        tick();
    endtask

    function automatic logic [2:0] onehot_idx(input logic [4:0] v);
        for (int i = 0; i < 5; i++) begin
            if (v[i]) return 3'(i);
        end
        return 3'd7;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int          cnt;
        int          n;
        logic [2:0]  gi;
        logic [2:0]  got_g[5];
        logic [2:0]  exp_g[5];

        do_reset();

        // 1: LISTEN from INIT
        req_valid_i = 5'b00001;
        sb_push(K_HS, 8'h01);
        #1 check_val("t1_ready", req_ready_o, 5'b00001);
        tick();
        req_valid_i = '0;
        check_val("t1_evt_valid", evt_valid_o, 1);
        check_val("t1_evt_state", evt_state_o, 8'h01);
        evt_ready_i = 1'b1;
        tick();
        evt_ready_i = 1'b0;
        check_val("t1_busy_after", busy_o, 0);

        // 2: BROCKEN overrides CLOSE from CONNECTED
        set_state(8'h04);
        req_valid_i = 5'b10100;
        sb_push(K_HS, 8'h20);
        #1 check_val("t2_ready_brk", req_ready_o, 5'b10000);
        tick();
        req_valid_i = 5'b00100;
        check_val("t2_evt_state_brk", evt_state_o, 8'h20);
        check_val("t2_no_ready_issue", req_ready_o, 0);
        evt_ready_i = 1'b1;
        tick();
        evt_ready_i = 1'b0;
        #1 check_val("t2_ready_close", req_ready_o, 5'b00100);
        sb_push(K_HS, 8'h08);
        tick();
        req_valid_i = '0;
        check_val("t2_evt_state_close", evt_state_o, 8'h08);
        evt_ready_i = 1'b1;
        tick();
        evt_ready_i = 1'b0;

        // 3: illegal SHUTDOWN from INIT
        set_state(8'h00);
        req_valid_i = 5'b01000;
        sb_push(K_REJ, 8'h00);
        #1 check_val("t3_ready", req_ready_o, 5'b01000);
        tick();
        req_valid_i = '0;
        check_val("t3_reject", reject_o, 1);
        check_val("t3_evt_valid", evt_valid_o, 0);
        tick();
        check_val("t3_reject_pulse", reject_o, 0);
        check_val("t3_evt_valid2", evt_valid_o, 0);

        // 4a: CONNECT times out after exactly 8 cycles
        req_valid_i = 5'b00010;
        sb_push(K_TMO, 8'h00);
        tick();
        req_valid_i = '0;
        cnt = 0;
        for (int i = 0; i < 20 && evt_valid_o; i++) begin
            cnt++;
            tick();
        end
        check_val("t4_valid_cycles", cnt, 8);
        check_val("t4_timeout", timeout_o, 1);
        tick();
        check_val("t4_timeout_pulse", timeout_o, 0);

        // 4b: handshake on the last cycle wins
        req_valid_i = 5'b00010;
        sb_push(K_HS, 8'h02);
        tick();
        req_valid_i = '0;
        repeat (7) tick();
        check_val("t4b_valid_c8", evt_valid_o, 1);
        evt_ready_i = 1'b1;
        tick();
        evt_ready_i = 1'b0;
        check_val("t4b_evt_valid", evt_valid_o, 0);
        check_val("t4b_no_timeout", timeout_o, 0);
        tick();
        check_val("t4b_no_timeout2", timeout_o, 0);

        // 5: round-robin order, then reset mid-ISSUE
        set_state(8'h08);
        do_reset();
        exp_g[0] = 3'd0; exp_g[1] = 3'd1; exp_g[2] = 3'd2; exp_g[3] = 3'd3; exp_g[4] = 3'd0;
        for (int i = 0; i < 5; i++) got_g[i] = 3'd7;
        evt_ready_i = 1'b1;
        req_valid_i = 5'b01111;
        #1;
        n = 0;
        for (int i = 0; i < 40 && n < 5; i++) begin
            if (req_ready_o != 5'b00000) begin
                gi = onehot_idx(req_ready_o);
                got_g[n] = gi;
                n++;
                if (n == 5) begin
                    evt_ready_i = 1'b0;
                end else if (gi < 3'd2) begin
                    sb_push(K_HS, (gi == 3'd0) ? 8'h01 : 8'h02);
                end else begin
                    sb_push(K_REJ, 8'h00);
                end
            end
            if (n < 5) tick();
        end
        check_val("t5_grant_count", n, 5);
        for (int i = 0; i < 5; i++) begin
            check_val($sformatf("t5_grant%0d", i), got_g[i], exp_g[i]);
        end
        tick();
        req_valid_i = '0;
        check_val("t5_issue_before_rst", evt_valid_o, 1);
        core_rst = 1'b1;
        tick();
        check_val("t5_evt_valid_rst", evt_valid_o, 0);
        check_val("t5_busy_rst", busy_o, 0);
        check_val("t5_reject_rst", reject_o, 0);
        check_val("t5_timeout_rst", timeout_o, 0);
        core_rst    = 1'b0;
        req_valid_i = 5'b01111;
        #1 check_val("t5_ptr_reset", req_ready_o, 5'b00001);
        sb_push(K_HS, 8'h01);
        tick();
        req_valid_i = '0;
        evt_ready_i = 1'b1;
        tick();
        evt_ready_i = 1'b0;
        tick();
        tick();

        check_val("sb_empty", sb_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
